// File: rtl/ring_sched_pkg.sv
// Shared constants and the rotating-priority pick function for the ring slot scheduler.
package ring_sched_pkg;

  localparam int N_REQ = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // First set request at or above the one-hot pointer position, wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req,
                                         input logic [N_REQ-1:0] ptr);
    logic [1:0] base;
    logic [1:0] cand;
    logic [1:0] win;
    logic       found;
    base  = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ptr[i]) base = i[1:0];
    end
    win   = base;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = base + i[1:0];
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/decoder_2to4.sv
// Binary-to-one-hot decoder; output forced to zero while clearn is low.
module decoder_2to4 (
  input  logic [1:0] idx,
  input  logic       clearn,
  output logic [3:0] dec
);

  assign dec = clearn ? (4'b0001 << idx) : 4'b0000;

endmodule

// File: rtl/ring_slot_scheduler.sv
// Round-robin slot scheduler for 4 requesters: grant one cycle after request, held
// until release or MAX_HOLD expiry, then one dead GAP cycle before the next grant.
module ring_slot_scheduler
  import ring_sched_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       grant_idx,
  output logic             busy,
  output logic             timeout
);

  logic [1:0]        state;
  logic [N_REQ-1:0]  ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [N_REQ-1:0]  next_ptr;
  logic              owner_req;
  logic              hold_done;

  assign next_ptr  = 4'b0001 << (grant_idx + 2'd1);
  assign owner_req = req[grant_idx];
  assign hold_done = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= S_IDLE;
      ptr       <= 4'b0001;
      grant_idx <= 2'd0;
      busy      <= 1'b0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_BUSY: begin
          // A release on the expiry cycle counts as normal, so timeout only if still requesting.
          if (!owner_req || hold_done) begin
            state   <= S_GAP;
            busy    <= 1'b0;
            timeout <= owner_req;
            ptr     <= next_ptr;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          timeout <= 1'b0;
          if (enable && |req) begin
            state     <= S_BUSY;
            grant_idx <= rr_pick(req, ptr);
            busy      <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  decoder_2to4 u_grant_dec (
    .idx    (grant_idx),
    .clearn (busy),
    .dec    (grant)
  );

endmodule
